lan_bus_arbiter: RTL and testbench
==================================

Name: lan_bus_arbiter

Overview:
Shares the LAN controller's 16-bit asynchronous host bus (LanAddr/LanData/LanCs/LanRd/LanWr) between NREQ client blocks, such as the init sequencer and the socket data mover. Each client posts single-word read or write requests. The block grants requests round-robin and runs one timed bus cycle per grant: setup, strobe, hold. It returns read data and a one-cycle Ack. It sits between the client FSMs and the top-level LanData tristate.

Parameters:
NREQ, 2, number of requesters (2..4)
SETUP_CYC, 5, cycles with address valid and strobes high before the strobe (1..255)
STRB_CYC, 5, cycles with LanCs and LanRd/LanWr low (1..255)
HOLD_CYC, 5, cycles with strobes high after the strobe before Ack (1..255)

Ports:
Clk  in  1  system clock; single clock domain
Rst  in  1  reset; synchronous, active-high
ReqValid  in  NREQ  per-requester request, held high until Ack
ReqWr  in  NREQ  1 = write, 0 = read
ReqAddr  in  NREQ*10  flattened; requester i uses bits [i*10+9:i*10]
ReqWData  in  NREQ*16  flattened write data
ReqAck  out  NREQ  one-cycle completion pulse
ReqRData  out  16  read data of the last completed read; shared by all requesters
LanAddr  out  10  bus address
LanCs  out  1  chip select, active low
LanRd  out  1  read strobe, active low
LanWr  out  1  write strobe, active low
LanDataOut  out  16  write data to the top-level tristate
LanDataOe  out  1  1 = drive LanData; the top level assigns LanData = Oe ? DataOut : 16'hz
LanDataIn  in  16  LanData sampled from the pad
Grant  out  clog2(NREQ)  index of the owning or last-owning requester (debug)

Behaviour:
- Reset values: LanCs=LanRd=LanWr=1, LanDataOe=0, LanAddr=0, LanDataOut=0, ReqAck=0, ReqRData=0, Grant=0, round-robin pointer=0, state IDLE.
- Reset applied mid-transaction: strobes return high and Oe goes to 0 on the same edge. The transaction is dropped with no Ack.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States are IDLE, SETUP, STROBE and HOLD. An 8-bit phase counter loads N-1 on phase entry, and the phase ends when the counter reaches 0.
- IDLE:
  - Eligible requesters are those with ReqValid=1 and ReqAck=0 in that cycle. This lets a requester see its Ack and drop Req without being re-granted.
  - Grant goes to the first eligible index starting at the pointer and wrapping.
  - On grant, latch Grant, LanAddr, the write flag and LanDataOut, then enter SETUP.
  - If no requester is eligible, stay in IDLE.
- SETUP (SETUP_CYC cycles): LanCs, LanRd and LanWr are high. LanDataOe equals the write flag.
- STROBE (STRB_CYC cycles):
  - LanCs=0.
  - For a read, LanRd=0. On the last STROBE cycle edge, ReqRData <= LanDataIn.
  - For a write, LanWr=0.
- HOLD (HOLD_CYC cycles):
  - Strobes are high. For writes, LanDataOe stays 1 through HOLD and drops on the return to IDLE.
  - On the last HOLD edge: ReqAck[Grant] <= 1 for one cycle, pointer <= Grant+1 mod NREQ, next state IDLE.
- Latency: the first cycle with Req visible in IDLE is cycle 0. With defaults, Ack is high at cycle 16 and the next grant can occur at cycle 16.
- LanAddr and LanDataOut hold their last value in IDLE and change only on grant.
- Changes to Req inputs during a transaction are ignored; the latched copies are used.
- ReqRData holds its value until the next read completes. For writes it is unchanged.

Optional Feature:
LAN_BUS_TURNAROUND_EN.
- Defined: a read granted immediately after a write inserts one extra IDLE cycle with Oe=0 before SETUP, to avoid bus contention. With defaults, Ack for that read arrives at cycle 17.
- Undefined: no extra cycle; timing is exactly as in Behaviour.

Decomposition:
- Package lan_bus_pkg:
  - state enum (IDLE/SETUP/STROBE/HOLD)
  - LAN_AW=10, LAN_DW=16
  - reset constants for strobes
  - register address constants shared with clients (MR, SHAR 0x08/0x0A/0x0C, SUBR 0x14/0x16, SIPR 0x18/0x1A, IDR 0xFE)
- Sub-module lan_rr_pick: combinational round-robin selector. Inputs are the eligible vector and the pointer; outputs are a found flag and an index.

Test Plan:
- Write: requester 0 writes addr 0x008, data 0xAABB, defaults. Required: LanCs low exactly 5 consecutive cycles, LanWr low in the same cycles, LanRd never low, Oe high from cycle 1 to cycle 15, ReqAck[0] a single pulse at cycle 16.
- Read: requester 1 reads addr 0x0FE with LanDataIn=0x5300 during STROBE. Required: LanRd low for 5 cycles, Oe never high, ReqRData=0x5300, ReqAck[1] pulse, LanWr stays 1.
- Contention: both requesters hold Req continuously, 4 transactions. Required: grants in the order 0,1,0,1, and Ack never asserted for two requesters in the same cycle.
- Ack/Req handshake: requester 0 drops Req in its Ack cycle. Required: no second transaction starts; the bus stays IDLE with strobes high.
- Reset mid-STROBE: assert Rst at the 3rd strobe cycle. Required: Cs/Rd/Wr=1 and Oe=0 on the next edge, no Ack, Grant=0. A new request afterwards completes normally.
- LAN_BUS_TURNAROUND_EN: a write from requester 0 followed by a pending read from requester 1. Required: read Ack 17 cycles after the write Ack with the macro defined, 16 without it.

Source files
------------

// File: rtl/lan_bus_pkg.sv
// lan_bus_pkg: shared types and constants for the LAN controller host-bus arbiter
// (lan_bus_arbiter) and the client blocks that post requests to it.
//   - bus widths (10-bit address, 16-bit data)
//   - arbiter state enum
//   - idle level of the active-low strobes
//   - controller register addresses used by the clients
package lan_bus_pkg;

    localparam int unsigned LAN_AW = 10;
    localparam int unsigned LAN_DW = 16;

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} lan_state_e;

    // LanCs/LanRd/LanWr are active low; this is their released level.
    localparam logic STRB_INACTIVE = 1'b1;

    // Controller register map shared with the client FSMs.
    localparam logic [LAN_AW-1:0] REG_MR    = 10'h000;
    localparam logic [LAN_AW-1:0] REG_SHAR0 = 10'h008;
    localparam logic [LAN_AW-1:0] REG_SHAR1 = 10'h00A;
    localparam logic [LAN_AW-1:0] REG_SHAR2 = 10'h00C;
    localparam logic [LAN_AW-1:0] REG_SUBR0 = 10'h014;
    localparam logic [LAN_AW-1:0] REG_SUBR1 = 10'h016;
    localparam logic [LAN_AW-1:0] REG_SIPR0 = 10'h018;
    localparam logic [LAN_AW-1:0] REG_SIPR1 = 10'h01A;
    localparam logic [LAN_AW-1:0] REG_IDR   = 10'h0FE;

    // Phase counter load value: a phase of n cycles counts n-1 down to 0.
    function automatic logic [7:0] phase_load(input int unsigned cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/lan_rr_pick.sv
// lan_rr_pick: combinational round-robin selector.
// Ports:
//   elig  - eligible requester vector
//   ptr   - index with highest priority this round
//   found - at least one requester is eligible
//   idx   - first eligible index at or after ptr, wrapping
module lan_rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] elig,
    input  logic [PW-1:0]   ptr,
    output logic            found,
    output logic [PW-1:0]   idx
);

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = (int'(ptr) + k) % int'(NREQ);
            if (!found && elig[j[PW-1:0]]) begin
                found = 1'b1;
                idx   = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/lan_bus_arbiter.sv
// lan_bus_arbiter: shares the LAN controller 16-bit asynchronous host bus between NREQ
// clients. Requests are granted round-robin; each grant runs one setup/strobe/hold bus
// cycle and ends with a one-cycle ReqAck. All outputs are registered.
// Ports:
//   Clk, Rst                        - clock, synchronous active-high reset
//   ReqValid/ReqWr/ReqAddr/ReqWData - per-requester request (addr/data flattened)
//   ReqAck, ReqRData                - completion pulse, data of the last completed read
//   LanAddr, LanCs, LanRd, LanWr    - bus address and active-low strobes
//   LanDataOut, LanDataOe, LanDataIn - data pad: drive value, drive enable, sampled pad
//   Grant                           - owning or last-owning requester (debug)
// Build option: LAN_BUS_TURNAROUND_EN inserts one idle cycle before a read that
// directly follows a write, so the controller never drives into our write data.
module lan_bus_arbiter
    import lan_bus_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned SETUP_CYC = 5,
    parameter int unsigned STRB_CYC  = 5,
    parameter int unsigned HOLD_CYC  = 5
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           ReqValid,
    input  logic [NREQ-1:0]           ReqWr,
    input  logic [NREQ*LAN_AW-1:0]    ReqAddr,
    input  logic [NREQ*LAN_DW-1:0]    ReqWData,
    output logic [NREQ-1:0]           ReqAck,
    output logic [LAN_DW-1:0]         ReqRData,
    output logic [LAN_AW-1:0]         LanAddr,
    output logic                      LanCs,
    output logic                      LanRd,
    output logic                      LanWr,
    output logic [LAN_DW-1:0]         LanDataOut,
    output logic                      LanDataOe,
    input  logic [LAN_DW-1:0]         LanDataIn,
    output logic [$clog2(NREQ)-1:0]   Grant
);

    localparam int unsigned GW = $clog2(NREQ);

    lan_state_e          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [GW-1:0]       grant_q, grant_d, ptr_q, ptr_d;
    logic                wr_q, wr_d;
    logic [LAN_AW-1:0]   addr_q, addr_d;
    logic [LAN_DW-1:0]   dout_q, dout_d, rdata_q, rdata_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_q, oe_d;

    logic [LAN_AW-1:0]   addr_arr  [NREQ];
    logic [LAN_DW-1:0]   wdata_arr [NREQ];
    logic                found;
    logic [GW-1:0]       pick_idx;
    logic                hold_off;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            addr_arr[i]  = ReqAddr[i*LAN_AW +: LAN_AW];
            wdata_arr[i] = ReqWData[i*LAN_DW +: LAN_DW];
        end
    end

    // A requester whose Ack is showing is not eligible, so it can drop Req in time.
    lan_rr_pick #(
        .NREQ (NREQ),
        .PW   (GW)
    ) u_pick (
        .elig  (ReqValid & ~ack_q),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick_idx)
    );

`ifdef LAN_BUS_TURNAROUND_EN
    // Set for the idle cycle right after a write completes.
    logic turn_q, turn_d;
    assign hold_off = turn_q && !ReqWr[pick_idx];

    always_ff @(posedge Clk) begin
        if (Rst) turn_q <= 1'b0;
        else     turn_q <= turn_d;
    end
`else
    assign hold_off = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        ack_d   = '0;
`ifdef LAN_BUS_TURNAROUND_EN
        turn_d  = turn_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef LAN_BUS_TURNAROUND_EN
                turn_d = 1'b0;
`endif
                if (found && !hold_off) begin
                    grant_d = pick_idx;
                    wr_d    = ReqWr[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    dout_d  = wdata_arr[pick_idx];
                    cnt_d   = phase_load(SETUP_CYC);
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = phase_load(STRB_CYC);
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                if (cnt_q == 8'd0) begin
                    if (!wr_q) rdata_d = LanDataIn;
                    cnt_d   = phase_load(HOLD_CYC);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == 8'd0) begin
                    ack_d[grant_q] = 1'b1;
                    ptr_d   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d = StIdle;
`ifdef LAN_BUS_TURNAROUND_EN
                    turn_d  = wr_q;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // Bus pins follow the next state so they are registered together with it.
        cs_n_d = (state_d == StStrobe) ? ~STRB_INACTIVE : STRB_INACTIVE;
        rd_n_d = (state_d == StStrobe && !wr_d) ? ~STRB_INACTIVE : STRB_INACTIVE;
        wr_n_d = (state_d == StStrobe && wr_d) ? ~STRB_INACTIVE : STRB_INACTIVE;
        oe_d   = (state_d != StIdle) && wr_d;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            cs_n_q  <= STRB_INACTIVE;
            rd_n_q  <= STRB_INACTIVE;
            wr_n_q  <= STRB_INACTIVE;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            oe_q    <= oe_d;
        end
    end

    assign ReqAck     = ack_q;
    assign ReqRData   = rdata_q;
    assign LanAddr    = addr_q;
    assign LanCs      = cs_n_q;
    assign LanRd      = rd_n_q;
    assign LanWr      = wr_n_q;
    assign LanDataOut = dout_q;
    assign LanDataOe  = oe_q;
    assign Grant      = grant_q;

endmodule

// File: tb/tb_lan_bus_arbiter.sv
// tb_lan_bus_arbiter: self-checking bench for lan_bus_arbiter with default parameters.
// Expected Acks (requester, read data, cycle) are queued when a request is driven and
// compared when the DUT pulses ReqAck. Honours LAN_BUS_TURNAROUND_EN when defined.
module tb_lan_bus_arbiter;

`ifdef LAN_BUS_TURNAROUND_EN
    localparam int TA = 1;
`else
    localparam int TA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_wr = '0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_ack;
    logic [15:0] req_rdata;
    logic [9:0]  lan_addr;
    logic        lan_cs, lan_rd, lan_wr, lan_oe;
    logic [15:0] lan_dout, lan_din;
    logic [0:0]  grant;
    logic [15:0] bus_val = 16'h0000;

    // Controller model: drives the pad only while the read strobe is low.
    assign lan_din = lan_rd ? 16'hDEAD : bus_val;

    always #5 clk = ~clk;

    lan_bus_arbiter dut (
        .Clk        (clk),
        .Rst        (rst),
        .ReqValid   (req_valid),
        .ReqWr      (req_wr),
        .ReqAddr    (req_addr),
        .ReqWData   (req_wdata),
        .ReqAck     (req_ack),
        .ReqRData   (req_rdata),
        .LanAddr    (lan_addr),
        .LanCs      (lan_cs),
        .LanRd      (lan_rd),
        .LanWr      (lan_wr),
        .LanDataOut (lan_dout),
        .LanDataOe  (lan_oe),
        .LanDataIn  (lan_din),
        .Grant      (grant)
    );

    typedef struct {
        int          idx;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_rdata = 16'h0000;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_compare(input logic [1:0] ack, input logic [15:0] rdata, input int k);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        check("ack_vec", {30'd0, ack}, 32'd1 << e.idx);
        check("rdata", {16'd0, rdata}, {16'd0, e.rdata});
        check("ack_cycle", k, e.cyc);
    endtask

    // One transaction from an otherwise idle bus; cycle 0 is the first cycle Req is seen.
    task automatic run_txn(input int idx, input logic wr, input logic [9:0] addr,
                           input logic [15:0] data);
        int k, cs_n, rd_n, wr_n, oe_n, oe_first, oe_last, skew, viol;
        logic [9:0]  addr_seen;
        logic [15:0] dout_seen;
        logic        done;
        k = 0; cs_n = 0; rd_n = 0; wr_n = 0; oe_n = 0; oe_first = -1; oe_last = -1;
        skew = 0; viol = 0; addr_seen = '0; dout_seen = '0; done = 1'b0;
        @(posedge clk); #1;
        req_valid[idx]          = 1'b1;
        req_wr[idx]             = wr;
        req_addr[idx*10 +: 10]  = addr;
        req_wdata[idx*16 +: 16] = data;
        if (!wr) model_rdata = bus_val;
        sb.push_back('{idx, model_rdata, 16});
        while (!done && k <= 40) begin
            @(negedge clk);
            if (!lan_cs) begin
                cs_n++;
                if (cs_n == 1) addr_seen = lan_addr;
            end
            if (!lan_rd) rd_n++;
            if (!lan_wr) wr_n++;
            if ((wr ? lan_wr : lan_rd) != lan_cs) skew++;
            if (lan_oe) begin
                oe_n++;
                if (oe_first < 0) oe_first = k;
                oe_last   = k;
                dout_seen = lan_dout;
            end
            if (req_ack != 2'b00) begin
                sb_compare(req_ack, req_rdata, k);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        if (!done) check("ack_timeout", k, 16);
        check("cs_low_cycles", cs_n, 5);
        check(wr ? "wr_low_cycles" : "rd_low_cycles", wr ? wr_n : rd_n, 5);
        check(wr ? "rd_never_low" : "wr_never_low", wr ? rd_n : wr_n, 0);
        check("strobe_vs_cs", skew, 0);
        check("lan_addr", {22'd0, addr_seen}, {22'd0, addr});
        if (wr) begin
            check("oe_first", oe_first, 1);
            check("oe_last", oe_last, 15);
            check("lan_dout", {16'd0, dout_seen}, {16'd0, data});
        end else begin
            check("oe_never_high", oe_n, 0);
        end
        // Req is still high in the Ack cycle and dropped afterwards: no re-grant allowed.
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (!lan_cs || !lan_rd || !lan_wr || lan_oe || req_ack != 2'b00) viol++;
        end
        check("idle_after_ack", viol, 0);
        check("addr_hold", {22'd0, lan_addr}, {22'd0, addr});
    endtask

    // Both requesters hold Req: 0 writes, 1 reads; each drops Req after its 2nd Ack.
    task automatic run_contention();
        int k, nack, dbl;
        int acks [2];
        logic [1:0] drop;
        k = 0; nack = 0; dbl = 0; acks[0] = 0; acks[1] = 0; drop = '0;
        @(posedge clk); #1;
        bus_val   = 16'hC0A8;
        req_wr    = 2'b01;
        req_addr  = {10'h018, 10'h00A};
        req_wdata = {16'h0000, 16'h1111};
        req_valid = 2'b11;
        sb.push_back('{0, model_rdata, 16});
        model_rdata = bus_val;
        sb.push_back('{1, model_rdata, 32 + TA});
        sb.push_back('{0, model_rdata, 48 + TA});
        sb.push_back('{1, model_rdata, 64 + 2 * TA});
        while (nack < 4 && k < 150) begin
            @(negedge clk);
            if ($countones(req_ack) > 1) dbl++;
            if (req_ack != 2'b00) begin
                sb_compare(req_ack, req_rdata, k);
                nack++;
                for (int i = 0; i < 2; i++) begin
                    if (req_ack[i]) begin
                        acks[i]++;
                        if (acks[i] == 2) drop[i] = 1'b1;
                    end
                end
            end
            @(posedge clk); #1;
            req_valid = req_valid & ~drop;
            k++;
        end
        check("contention_acks", nack, 4);
        check("dbl_ack", dbl, 0);
        req_valid = '0;
    endtask

    task automatic run_reset_mid_strobe();
        int k, cs_n, viol;
        k = 0; cs_n = 0; viol = 0;
        @(posedge clk); #1;
        req_wr[1]          = 1'b1;
        req_addr[19:10]    = 10'h01A;
        req_wdata[31:16]   = 16'h5A5A;
        req_valid[1]       = 1'b1;
        while (cs_n < 3 && k < 40) begin
            @(negedge clk);
            if (!lan_cs) cs_n++;
            if (cs_n < 3) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("rst_reached_strobe", cs_n, 3);
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rdata = 16'h0000;
        @(negedge clk);
        check("rst_strobes", {29'd0, lan_cs, lan_rd, lan_wr}, 32'd7);
        check("rst_oe", {31'd0, lan_oe}, 32'd0);
        check("rst_ack", {30'd0, req_ack}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd0);
        check("rst_addr", {22'd0, lan_addr}, 32'd0);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (req_ack != 2'b00 || !lan_cs) viol++;
        end
        check("no_ack_after_rst", viol, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_strobes", {29'd0, lan_cs, lan_rd, lan_wr}, 32'd7);
        check("reset_oe", {31'd0, lan_oe}, 32'd0);
        check("reset_addr", {22'd0, lan_addr}, 32'd0);
        check("reset_dout", {16'd0, lan_dout}, 32'd0);
        check("reset_ack", {30'd0, req_ack}, 32'd0);
        check("reset_rdata", {16'd0, req_rdata}, 32'd0);
        check("reset_grant", {31'd0, grant}, 32'd0);

        run_txn(0, 1'b1, 10'h008, 16'hAABB);
        bus_val = 16'h5300;
        run_txn(1, 1'b0, 10'h0FE, 16'h0000);
        run_contention();
        repeat (10) @(posedge clk);
        run_reset_mid_strobe();
        bus_val = 16'hFF00;
        run_txn(0, 1'b0, 10'h014, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
